// File: rtl/cpu_seq_ctrl.sv
// rtl/cpu_seq_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/WB sequencer for the MiniCPU datapath
module cpu_seq_ctrl #(
   parameter logic [3:0] HALT_OP     = 4'hF,
   parameter int         MEM_TIMEOUT = 8,
   parameter int         CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             step,
   input  logic             mem_ready,
   input  logic [3:0]       opcode,
   input  logic             jmp_type,
   input  logic             alu_load,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             exec_en,
   output logic             wb_en,
   output logic             pc_inc,
   output logic             pc_load,
   output logic             busy,
   output logic             halted,
   output logic             fault,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   // Fetch-wait limit; the counter holds completed wait cycles, so it never exceeds MEM_TIMEOUT-1.
   localparam logic [7:0] TLIM = 8'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           cur_state, nxt_state;
   logic [7:0]       tcnt, tcnt_nxt;
   logic             step_latch, step_latch_nxt;
   logic             fault_q, fault_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;

   // State, timeout counter, step latch, sticky fault and retired count registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state  <= S_IDLE;
         tcnt       <= 8'd0;
         step_latch <= 1'b0;
         fault_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         cur_state  <= nxt_state;
         tcnt       <= tcnt_nxt;
         step_latch <= step_latch_nxt;
         fault_q    <= fault_nxt;
         cnt_q      <= cnt_nxt;
      end
   end

   // Next-state logic and stage enables; WB controls also depend on the live jump inputs.
   always_comb begin
      nxt_state      = cur_state;
      tcnt_nxt       = tcnt;
      step_latch_nxt = step_latch;
      fault_nxt      = fault_q;
      cnt_nxt        = cnt_q;
      fetch_en       = 1'b0;
      decode_en      = 1'b0;
      exec_en        = 1'b0;
      wb_en          = 1'b0;
      pc_inc         = 1'b0;
      pc_load        = 1'b0;
      busy           = 1'b0;
      halted         = 1'b0;
      case (cur_state)
         S_IDLE: begin
            if (run) begin
               nxt_state      = S_FETCH;
               step_latch_nxt = 1'b0;
            end else if (step) begin
               nxt_state      = S_FETCH;
               step_latch_nxt = 1'b1;
            end
         end
         S_FETCH: begin
            fetch_en = 1'b1;
            busy     = 1'b1;
            if (mem_ready) begin
               nxt_state = S_DECODE;
               tcnt_nxt  = 8'd0;
            end else if (tcnt + 8'd1 >= TLIM) begin
               nxt_state = S_HALT;
               fault_nxt = 1'b1;
               tcnt_nxt  = 8'd0;
            end else begin
               tcnt_nxt = tcnt + 8'd1;
            end
         end
         S_DECODE: begin
            decode_en = 1'b1;
            busy      = 1'b1;
            nxt_state = (opcode == HALT_OP) ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            exec_en   = 1'b1;
            busy      = 1'b1;
            nxt_state = S_WB;
         end
         S_WB: begin
            busy    = 1'b1;
            wb_en   = ~jmp_type;
            pc_load = jmp_type & alu_load;
            pc_inc  = ~(jmp_type & alu_load);
            cnt_nxt = cnt_q + CNT_ONE;
            if (step_latch) begin
               nxt_state      = S_IDLE;
               step_latch_nxt = 1'b0;
            end else if (run) begin
               nxt_state = S_FETCH;
            end else begin
               nxt_state = S_IDLE;
            end
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            nxt_state = S_IDLE;
         end
      endcase
   end

   assign fault       = fault_q;
   assign state       = cur_state;
   assign instr_count = cnt_q;

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
Multi-cycle sequencer for the MiniCPU datapath: PC, instruction memory, decoder, register file and ALU.
- Steps each instruction through FETCH, DECODE, EXEC and WB, one-hot enabling each stage.
- Drives the PC increment and jump-load controls.
- Supports free-run and single-step operation, a HALT opcode, and an instruction-memory timeout fault.
- Sits at CPU top level between the stage blocks and the debug/run controls.

Parameters:
HALT_OP, 4'hF, opcode that stops the sequencer.
MEM_TIMEOUT, 8, maximum FETCH cycles waiting for mem_ready before fault (range 1..255).
CNT_W, 16, width of retired-instruction counter.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
run  in  1  level: free-run enable.
step  in  1  single-cycle pulse: execute exactly one instruction while run=0.
mem_ready  in  1  instruction memory has valid code for current pc.
opcode  in  4  decoded opcode from decoder.
type  in  1  decoded jump-type flag (1 = jump instruction).
alu_load  in  1  ALU branch-taken indication (valid in WB).
fetch_en  out  1  memory/IR capture enable.
decode_en  out  1  decoder enable.
exec_en  out  1  ALU enable.
wb_en  out  1  register-file writeback enable.
pc_inc  out  1  PC count-up enable.
pc_load  out  1  PC load of jump address.
busy  out  1  high in FETCH/DECODE/EXEC/WB.
halted  out  1  high in HALT state.
fault  out  1  sticky memory-timeout flag.
state  out  3  encoded state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5.
instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (synchronous): state=IDLE, instr_count=0, fault=0, timeout counter=0, step latch=0. All enables, busy and halted read 0 in the cycle after reset is sampled. Reset mid-instruction aborts it; no pc_inc/pc_load/wb_en is issued.
- Outputs are Moore-decoded from the state register, except wb_en/pc_inc/pc_load in WB, which also depend on that cycle's type/alu_load. At most one stage enable is high in any cycle.
- IDLE:
  - run=1 -> FETCH, step latch=0.
  - else step=1 -> FETCH, step latch=1.
  - run has priority when both are high.
- FETCH:
  - fetch_en=1; the timeout counter increments each cycle.
  - mem_ready=1 -> DECODE, counter cleared.
  - If the counter reaches MEM_TIMEOUT with mem_ready=0 -> HALT with fault=1.
  - mem_ready on the same cycle as the limit wins: go to DECODE, no fault.
- DECODE: decode_en=1 for exactly one cycle.
  - opcode==HALT_OP -> HALT; the PC is not advanced and instr_count is unchanged.
  - otherwise -> EXEC.
- EXEC: exec_en=1 for one cycle -> WB.
- WB: one cycle.
  - wb_en=1 iff type=0.
  - type=1 and alu_load=1: pc_load=1, pc_inc=0.
  - otherwise: pc_inc=1. Taken and not-taken jumps both cost exactly one cycle.
  - instr_count increments and wraps 2^CNT_W-1 -> 0.
  - Next state: step latch=1 -> IDLE (latch cleared); else run=1 -> FETCH; else IDLE.
- run deasserted mid-instruction: the current instruction completes through WB, then goes to IDLE.
- step pulses arriving while busy or halted are ignored and not queued.
- HALT: halted=1, all enables 0. Left only by reset. fault holds its value until reset.
- Throughput: 4 cycles per instruction with zero-wait memory; +1 cycle per FETCH wait cycle.

Test Plan:
- Free-run basic: reset 2 cycles, run=1, mem_ready=1, opcode=4'h1, type=0 -> state sequence 1,2,3,4 repeating. wb_en and pc_inc high every 4th cycle. instr_count=5 after 20 cycles from first FETCH.
- Jump taken/not taken: WB with type=1, alu_load=1 -> pc_load=1, pc_inc=0, wb_en=0. Next instruction with type=1, alu_load=0 -> pc_inc=1, pc_load=0.
- Single-step: run=0, one-cycle step pulse -> exactly one FETCH..WB pass, then state=0. instr_count +1. A second step pulse during EXEC is ignored.
- Memory wait and timeout (MEM_TIMEOUT=8):
  - mem_ready low 3 cycles then high -> DECODE on the 4th FETCH cycle, no fault.
  - mem_ready held low -> state=5, fault=1, halted=1 after 8 FETCH cycles.
- HALT opcode: opcode=4'hF in DECODE -> state=5 next cycle, pc_inc never asserted, instr_count unchanged. Toggling run has no effect. reset -> state=0, halted=0, fault=0.
- Reset mid-op and wrap: assert reset during EXEC -> next cycle all outputs 0, no wb_en. With CNT_W=4, run 16 instructions -> instr_count wraps to 0.
